// File: rtl/program_sequencer.sv
// Program counter with jump/jz/jnz, call/ret through a return-address stack and sticky misuse flags.
// Optional macro PC_RELATIVE_EN: relative=1 makes branch/call targets result + signed jump_address.
module program_sequencer #(
  parameter int unsigned WORD_WIDTH  = 8,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned DEPTH_W     = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  jump,
  input  logic                  jz,
  input  logic                  jnz,
  input  logic                  zero_flag,
  input  logic                  call,
  input  logic                  ret,
  input  logic                  relative,
  input  logic [WORD_WIDTH-1:0] jump_address,
  output logic [WORD_WIDTH-1:0] result,
  output logic [DEPTH_W-1:0]    depth,
  output logic                  stack_overflow,
  output logic                  stack_underflow
);

  logic [WORD_WIDTH-1:0] result_q, result_d;
  logic [DEPTH_W-1:0]    depth_q, depth_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  push;
  logic [WORD_WIDTH-1:0] pc_inc;
  logic [WORD_WIDTH-1:0] target;
  logic [WORD_WIDTH-1:0] stack_top;
  logic [WORD_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic                  stack_full;
  logic                  stack_empty;
  logic                  cond_taken;

  assign pc_inc      = result_q + WORD_WIDTH'(1);
  assign stack_full  = (depth_q == DEPTH_W'(STACK_DEPTH));
  assign stack_empty = (depth_q == '0);
  // Both jz and jnz asserted makes one of these terms true, so the jump is taken unconditionally.
  assign cond_taken  = (jz && zero_flag) || (jnz && !zero_flag);

`ifdef PC_RELATIVE_EN
  // Same-width modulo add equals adding the sign-extended offset.
  assign target = relative ? (result_q + jump_address) : jump_address;
`else
  logic unused_relative;
  assign unused_relative = relative;
  assign target          = jump_address;
`endif

  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (depth_q == DEPTH_W'(i + 1)) stack_top = stack_q[i];
    end
  end

  always_comb begin
    result_d    = result_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push        = 1'b0;
    if (enable) begin
      if (ret) begin
        if (!stack_empty) begin
          result_d = stack_top;
          depth_d  = depth_q - DEPTH_W'(1);
        end else begin
          result_d    = pc_inc;
          underflow_d = 1'b1;
        end
      end else if (call) begin
        if (!stack_full) begin
          push     = 1'b1;
          result_d = target;
          depth_d  = depth_q + DEPTH_W'(1);
        end else begin
          result_d   = pc_inc;
          overflow_d = 1'b1;
        end
      end else if (jump || cond_taken) begin
        result_d = target;
      end else begin
        result_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q    <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      depth_q     <= depth_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack contents are unreadable while depth is zero, so they need no reset.
  always_ff @(posedge clock) begin
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (push && !reset && depth_q == DEPTH_W'(i)) stack_q[i] <= pc_inc;
    end
  end

  assign result          = result_q;
  assign depth           = depth_q;
  assign stack_overflow  = overflow_q;
  assign stack_underflow = underflow_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Self-checking bench for program_sequencer: directed scenarios plus randomized strobes
// compared cycle by cycle against a queue-based reference model.
module tb_program_sequencer;

  localparam int unsigned W    = 8;
  localparam int unsigned SD   = 4;
  localparam int unsigned DW   = $clog2(SD + 1);
  localparam int unsigned MASK = (1 << W) - 1;

  logic          clock = 1'b0;
  logic          reset, enable, jump, jz, jnz, zero_flag, call, ret, relative;
  logic [W-1:0]  jump_address;
  logic [W-1:0]  result;
  logic [DW-1:0] depth;
  logic          stack_overflow, stack_underflow;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned m_pc = 0;
  int unsigned m_stack[$];
  bit          m_ovf = 1'b0;
  bit          m_unf = 1'b0;

  program_sequencer #(
    .WORD_WIDTH (W),
    .STACK_DEPTH(SD)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .enable         (enable),
    .jump           (jump),
    .jz             (jz),
    .jnz            (jnz),
    .zero_flag      (zero_flag),
    .call           (call),
    .ret            (ret),
    .relative       (relative),
    .jump_address   (jump_address),
    .result         (result),
    .depth          (depth),
    .stack_overflow (stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    reset        = 1'b0;
    enable       = 1'b1;
    jump         = 1'b0;
    jz           = 1'b0;
    jnz          = 1'b0;
    zero_flag    = 1'b0;
    call         = 1'b0;
    ret          = 1'b0;
    relative     = 1'b0;
    jump_address = '0;
  endtask

  // Reference behaviour derived from the priority rules, using a queue as the stack.
  task automatic model_step();
    int unsigned tgt;
    int unsigned inc;
    tgt = int'(jump_address);
`ifdef PC_RELATIVE_EN
    if (relative) tgt = (m_pc + int'(jump_address)) & MASK;
`endif
    inc = (m_pc + 1) & MASK;
    if (reset) begin
      m_pc = 0;
      m_stack.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (enable) begin
      if (ret) begin
        if (m_stack.size() > 0) m_pc = m_stack.pop_back();
        else begin
          m_pc  = inc;
          m_unf = 1'b1;
        end
      end else if (call) begin
        if (m_stack.size() < SD) begin
          m_stack.push_back(inc);
          m_pc = tgt;
        end else begin
          m_pc  = inc;
          m_ovf = 1'b1;
        end
      end else if (jump || (jz && zero_flag) || (jnz && !zero_flag)) begin
        m_pc = tgt;
      end else begin
        m_pc = inc;
      end
    end
  endtask

  task automatic step(input string tag);
    model_step();
    @(posedge clock);
    #1;
    check_eq({tag, "/result"}, 32'(result), m_pc);
    check_eq({tag, "/depth"}, 32'(depth), m_stack.size());
    check_eq({tag, "/overflow"}, 32'(stack_overflow), 32'(m_ovf));
    check_eq({tag, "/underflow"}, 32'(stack_underflow), 32'(m_unf));
  endtask

  task automatic goto(input logic [W-1:0] addr);
    idle();
    jump         = 1'b1;
    jump_address = addr;
    step("goto");
  endtask

  initial begin
    idle();
    reset = 1'b1;
    step("reset");
    check_eq("reset_result", 32'(result), 0);

    idle();
    for (int i = 0; i < 5; i++) step("incr");
    check_eq("incr_five", 32'(result), 5);

    goto(8'h10);
    enable       = 1'b0;
    jump         = 1'b1;
    jump_address = 8'h40;
    for (int i = 0; i < 3; i++) step("hold");
    check_eq("hold_result", 32'(result), 32'h10);
    enable = 1'b1;
    step("hold_release");
    check_eq("release_jump", 32'(result), 32'h40);

    goto(8'h20);
    idle();
    jz           = 1'b1;
    jump_address = 8'h80;
    step("jz_not_taken");
    check_eq("jz_nt", 32'(result), 32'h21);
    zero_flag = 1'b1;
    step("jz_taken");
    check_eq("jz_t", 32'(result), 32'h80);
    idle();
    jnz          = 1'b1;
    zero_flag    = 1'b1;
    jump_address = 8'h33;
    step("jnz_not_taken");
    check_eq("jnz_nt", 32'(result), 32'h81);

    goto(8'h05);
    idle();
    call         = 1'b1;
    jump_address = 8'h30;
    step("call1");
    jump_address = 8'h60;
    step("call2");
    check_eq("nest_depth", 32'(depth), 2);
    idle();
    ret = 1'b1;
    step("ret1");
    check_eq("ret1_result", 32'(result), 32'h31);
    step("ret2");
    check_eq("ret2_result", 32'(result), 32'h06);

    idle();
    call = 1'b1;
    for (int i = 0; i < 5; i++) begin
      jump_address = W'($urandom);
      step("call_fill");
    end
    check_eq("ovf_flag", 32'(stack_overflow), 1);
    check_eq("ovf_depth", 32'(depth), SD);
    idle();
    ret = 1'b1;
    for (int i = 0; i < 5; i++) step("ret_drain");
    check_eq("unf_flag", 32'(stack_underflow), 1);
    idle();
    reset = 1'b1;
    step("flag_reset");
    check_eq("flags_clear", {30'd0, stack_overflow, stack_underflow}, 0);

    goto(8'h11);
    idle();
    call         = 1'b1;
    jump_address = 8'h20;
    step("call_for_ret");
    idle();
    ret          = 1'b1;
    jump         = 1'b1;
    jump_address = 8'h77;
    step("ret_vs_jump");
    check_eq("ret_wins", 32'(result), 32'h12);

    goto(8'h50);
    idle();
    relative     = 1'b1;
    jump         = 1'b1;
    jump_address = 8'hF0;
    step("relative");
`ifdef PC_RELATIVE_EN
    check_eq("relative_target", 32'(result), 32'h40);
`else
    check_eq("absolute_target", 32'(result), 32'hF0);
`endif

    goto(8'hFF);
    idle();
    step("wrap");
    check_eq("wrap_result", 32'(result), 0);

    goto(8'hFF);
    idle();
    call         = 1'b1;
    jump_address = 8'h10;
    step("call_wrap");
    idle();
    ret = 1'b1;
    step("ret_wrap");
    check_eq("pushed_wrap", 32'(result), 0);

    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(0, 63) == 0);
      enable       = ($urandom_range(0, 3) != 0);
      jump         = ($urandom_range(0, 7) == 0);
      jz           = ($urandom_range(0, 5) == 0);
      jnz          = ($urandom_range(0, 5) == 0);
      zero_flag    = 1'($urandom);
      call         = ($urandom_range(0, 4) == 0);
      ret          = ($urandom_range(0, 4) == 0);
      relative     = 1'($urandom);
      jump_address = W'($urandom);
      step("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Parametrised successor to the CPU's program counter.
- Produces the instruction address `result` each cycle. Supports:
  - increment,
  - absolute jump,
  - conditional jump on zero (jz) and on not-zero (jnz),
  - subroutine call/return through an internal return-address stack.
- Sits between the instruction decoder (control strobes) and instruction memory (address).
- Stack misuse is flagged with sticky error flags.

Parameters:
- WORD_WIDTH, 8: address width; `result` wraps modulo 2^WORD_WIDTH.
- STACK_DEPTH, 4: number of return-address entries; must be ≥ 1.
- DEPTH_W, $clog2(STACK_DEPTH+1): width of the `depth` output.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  advance/update the PC this cycle; when low, all state holds.
- jump  input  1  unconditional jump to jump_address.
- jz  input  1  jump to jump_address if zero_flag=1.
- jnz  input  1  jump to jump_address if zero_flag=0.
- zero_flag  input  1  ALU zero flag, sampled in the same cycle as jz/jnz.
- call  input  1  push result+1, then jump to jump_address.
- ret  input  1  pop the top of stack into result.
- relative  input  1  relative-branch select; used only under PC_RELATIVE_EN.
- jump_address  input  WORD_WIDTH  branch/call target (or signed offset, see Optional Feature).
- result  output  WORD_WIDTH  current PC, registered.
- depth  output  DEPTH_W  number of valid stack entries.
- stack_overflow  output  1  sticky: a call was attempted while the stack was full.
- stack_underflow  output  1  sticky: a ret was attempted while the stack was empty.

Behaviour:
- Reset (synchronous, highest priority):
  - result=0, depth=0, stack_overflow=0, stack_underflow=0.
  - Stack contents don't-care; they are never readable when depth=0.
- enable=0 (and reset=0): result, depth, stack and flags all hold. Every strobe is ignored.
- enable=1: exactly one action per edge, chosen by fixed priority **ret > call > jump > jz/jnz > increment**.
  - ret:
    - depth>0: result ← stack[depth-1]; depth ← depth-1.
    - depth=0: result ← result+1; stack_underflow ← 1.
  - call:
    - depth<STACK_DEPTH: stack[depth] ← result+1 (wrapped); result ← target; depth ← depth+1.
    - depth=STACK_DEPTH: no push, no jump; result ← result+1; stack_overflow ← 1.
  - jump: result ← target.
  - Conditional jumps:
    - jz with zero_flag=1 → result ← target.
    - jnz with zero_flag=0 → result ← target.
    - If both jz and jnz are asserted, the jump is taken unconditionally.
    - Not taken → increment.
  - Increment: result ← result+1. Wraps from 2^WORD_WIDTH−1 to 0 with no flag.
- Latency:
  - Strobes and jump_address are sampled at the edge; the new result is visible after that edge (1-cycle latency).
  - No combinational path from any input to any output.
- Wrap of the pushed address: a call at result=2^WORD_WIDTH−1 pushes 0.
- Error flags are sticky. They clear only on reset; enable=0 does not clear them.
- depth never exceeds STACK_DEPTH and never goes negative.
- Reset asserted mid-subroutine discards all stack entries. The first action after reset starts from result=0.

Optional Feature:
- Macro: PC_RELATIVE_EN.
- Defined:
  - When relative=1, the target for jump/jz/jnz/call is result + sign-extended jump_address, modulo 2^WORD_WIDTH.
  - For call, the pushed value is still result+1.
  - When relative=0, the target is jump_address (absolute).
- Undefined:
  - The relative port exists but is ignored.
  - The target is always jump_address (absolute).
  - No adder for relative targets is synthesised.

Test Plan:
- Reset then 5 cycles with enable=1 and no strobes → result 0,1,2,3,4,5; depth=0; both flags 0.
- result=0x10 with enable=0 for 3 cycles, jump=1, jump_address=0x40 → result stays 0x10. Then enable=1 → result=0x40.
- jz=1 with zero_flag=0 at result=0x20 → 0x21. jz=1 with zero_flag=1 and jump_address=0x80 → 0x80. jnz=1 with zero_flag=1 → increment only.
- Nested calls at result=0x05 (target 0x30) and then at 0x30 (target 0x60) → depth 2. Two rets → result 0x31, then 0x06; depth 0.
- STACK_DEPTH=4: five consecutive calls → fifth call gives no jump, result=previous+1, stack_overflow=1, depth=4. Four rets plus one extra ret → stack_underflow=1, result increments. Reset → both flags 0.
- ret and jump together at depth=1 with top entry 0x12 → result=0x12 (ret wins). With PC_RELATIVE_EN: result=0x50, relative=1, jump=1, jump_address=0xF0 → result=0x40. Without the macro, the same stimulus → result=0xF0. Result=0xFF with no strobe → 0x00.
